// File: rtl/mil_pkg.sv
// Shared MIL-STD-1553 definitions: bit timing, sync limits, line-level
// encoding and the receive FSM state type.
package mil_pkg;

   // 50 MHz system clock, 1 Mbit/s bus.
   localparam int MIL_CLK_PER_BIT = 50;
   localparam int MIL_HALF_BIT    = MIL_CLK_PER_BIT / 2;
   localparam int MIL_SYNC_HALF   = (3 * MIL_CLK_PER_BIT) / 2;

   // Acceptance limits for the two sync halves.
   localparam int MIL_SYNC_MIN    = 60;
   localparam int MIL_SYNC_MAX1   = 115;

   // Half-width of the phase realignment window around mid-bit.
   localparam int MIL_RESYNC_WIN  = 8;

   // 16 data bits followed by one odd-parity bit.
   localparam int MIL_DATA_BITS   = 16;

   // Differential line level as seen after decode.
   localparam logic MIL_LINE_HI = 1'b1;
   localparam logic MIL_LINE_LO = 1'b0;

   typedef struct packed {
      logic vld;
      logic lvl;
   } line_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC1,
      ST_SYNC2,
      ST_DATA,
      ST_DONE
   } rx_state_t;

   // RXP high / RXN low is a logic one; equal lines carry no level.
   function automatic line_t line_decode(input logic p, input logic n);
      line_t r;
      r.vld = p ^ n;
      r.lvl = (p & ~n) ? MIL_LINE_HI : MIL_LINE_LO;
      return r;
   endfunction

endpackage

// File: rtl/mil_line_sync.sv
// Brings the asynchronous bus pair into the clock domain and reports the
// decoded line level, whether that level is valid, and level transitions.
module mil_line_sync
   import mil_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rxp,
   input  logic rxn,
   output logic lvl,
   output logic vld,
   output logic edg
);

   logic [1:0] p_sync;
   logic [1:0] n_sync;
   logic       lvl_d;
   logic       vld_d;
   line_t      line_now;

   // Two-flop synchronizers plus one stage of history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_sync <= 2'b00;
         n_sync <= 2'b00;
         lvl_d  <= 1'b0;
         vld_d  <= 1'b0;
      end else begin
         p_sync <= {p_sync[0], rxp};
         n_sync <= {n_sync[0], rxn};
         lvl_d  <= lvl;
         vld_d  <= vld;
      end
   end

   // A transition only counts between two valid levels.
   always_comb begin
      line_now = line_decode(p_sync[1], n_sync[1]);
      lvl      = line_now.lvl;
      vld      = line_now.vld;
      edg      = line_now.vld & vld_d & (line_now.lvl != lvl_d);
   end

endmodule

// File: rtl/mil_rxd.sv
// MIL-STD-1553 Manchester II word receiver: finds command or data sync,
// decodes 16 data bits plus odd parity and strobes each completed word.
module mil_rxd
   import mil_pkg::*;
#(
   parameter int CLK_PER_BIT = MIL_CLK_PER_BIT,
   parameter int SYNC_MIN    = MIL_SYNC_MIN,
   parameter int SYNC_MAX1   = MIL_SYNC_MAX1,
   parameter int RESYNC_WIN  = MIL_RESYNC_WIN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RXP,
   input  logic        RXN,
   output logic [15:0] dat,
   output logic        cw_dw,
   output logic        ce_wr,
   output logic        err_par,
   output logic        err_man,
   output logic        busy,
   output logic [4:0]  cb_bit
);

   localparam int PH_W  = $clog2(CLK_PER_BIT);
   localparam int RUN_W = $clog2(SYNC_MAX1 + 1) + 1;

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_PER_BIT - 1);
   localparam logic [PH_W-1:0]  PH_MID    = PH_W'(CLK_PER_BIT / 2);
   localparam logic [PH_W-1:0]  PH_S1     = PH_W'(CLK_PER_BIT / 4);
   localparam logic [PH_W-1:0]  PH_S2     = PH_W'(CLK_PER_BIT / 2 + CLK_PER_BIT / 4);
   localparam logic [PH_W-1:0]  PH_WIN_LO = PH_W'(CLK_PER_BIT / 2 - RESYNC_WIN);
   localparam logic [PH_W-1:0]  PH_WIN_HI = PH_W'(CLK_PER_BIT / 2 + RESYNC_WIN);
   localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_MIN   = RUN_W'(SYNC_MIN);
   localparam logic [RUN_W-1:0] RUN_MAX1  = RUN_W'(SYNC_MAX1);
   localparam logic [RUN_W-1:0] RUN_SAT   = '1;
   localparam logic [RUN_W-1:0] RUN_DATA  = RUN_W'((3 * CLK_PER_BIT) / 2 - 1);
   localparam logic [4:0]       PAR_IDX   = 5'(MIL_DATA_BITS);

   rx_state_t        state;
   rx_state_t        state_nx;
   logic             lvl;
   logic             vld;
   logic             edg;
   logic [RUN_W-1:0] run;
   logic [PH_W-1:0]  ph;
   logic [4:0]       cb;
   logic [15:0]      shreg;
   logic             s1;
   logic             s1_vld;
   logic             cw_pend;
   logic             par_ok;
   logic             sync_ok;
   logic             sync2_short;
   logic             at_s2;
   logic             bit_bad;
   logic             in_win;

   mil_line_sync u_line (
      .clk (clk),
      .rst (rst),
      .rxp (RXP),
      .rxn (RXN),
      .lvl (lvl),
      .vld (vld),
      .edg (edg)
   );

   // Decision terms shared by the next-state logic and the datapath.
   always_comb begin
      sync_ok     = edg && (run >= RUN_MIN) && (run <= RUN_MAX1);
      sync2_short = edg && (run < RUN_MIN);
      at_s2       = (ph == PH_S2);
      bit_bad     = !vld || !s1_vld || (lvl == s1);
      in_win      = (ph >= PH_WIN_LO) && (ph <= PH_WIN_HI);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: hunt for a sync pair, then walk the 17 bit cells.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (vld) state_nx = ST_SYNC1;
         end
         ST_SYNC1: begin
            if (!vld)         state_nx = ST_IDLE;
            else if (sync_ok) state_nx = ST_SYNC2;
         end
         ST_SYNC2: begin
            if (!vld)                 state_nx = ST_IDLE;
            else if (sync2_short)     state_nx = ST_SYNC1;
            else if (run == RUN_DATA) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (at_s2) begin
               if (bit_bad)            state_nx = ST_IDLE;
               else if (cb == PAR_IDX) state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      ce_wr   = (state == ST_DONE) && par_ok;
      err_par = (state == ST_DONE) && !par_ok;
      busy    = (state == ST_SYNC2) || (state == ST_DATA) || (state == ST_DONE);
      cb_bit  = cb;
   end

   // Run/phase counters, bit sampling, shift register and word results.
   // dat is loaded on the parity sample so it is already valid while the
   // DONE strobe is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         run     <= '0;
         ph      <= '0;
         cb      <= '0;
         shreg   <= '0;
         s1      <= 1'b0;
         s1_vld  <= 1'b0;
         cw_pend <= 1'b0;
         par_ok  <= 1'b0;
         dat     <= '0;
         cw_dw   <= 1'b0;
         err_man <= 1'b0;
      end else begin
         err_man <= 1'b0;
         case (state)
            ST_IDLE: begin
               run <= RUN_ONE;
               cb  <= '0;
            end
            ST_SYNC1: begin
               if (edg) begin
                  run <= RUN_ONE;
                  if (sync_ok) cw_pend <= ~lvl;
               end else if (run != RUN_SAT) begin
                  run <= run + 1'b1;
               end
            end
            ST_SYNC2: begin
               ph <= '0;
               cb <= '0;
               if (sync2_short)         run <= RUN_ONE;
               else if (run != RUN_SAT) run <= run + 1'b1;
            end
            ST_DATA: begin
               if (edg && in_win)      ph <= PH_MID;
               else if (ph == PH_LAST) ph <= '0;
               else                    ph <= ph + 1'b1;
               if (ph == PH_S1) begin
                  s1     <= lvl;
                  s1_vld <= vld;
               end
               if (at_s2) begin
                  if (bit_bad) begin
                     err_man <= 1'b1;
                  end else if (cb == PAR_IDX) begin
                     dat    <= shreg;
                     cw_dw  <= cw_pend;
                     par_ok <= ^{shreg, s1};
                  end else begin
                     shreg <= {shreg[14:0], s1};
                     cb    <= cb + 1'b1;
                  end
               end
            end
            default: begin
               run <= RUN_ONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mil_rxd.sv
// Directed bench for mil_rxd: drives Manchester words onto RXP/RXN and
// checks strobes, decoded data and timing against hand-computed values.
module tb_mil_rxd;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RXP = 1'b0;
   logic        RXN = 1'b0;
   logic [15:0] dat;
   logic        cw_dw;
   logic        ce_wr;
   logic        err_par;
   logic        err_man;
   logic        busy;
   logic [4:0]  cb_bit;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          ce_cnt = 0;
   int          par_cnt = 0;
   int          man_cnt = 0;
   int          busy_cnt = 0;
   int          last_ce_cyc = 0;
   int          prev_ce_cyc = 0;
   logic [15:0] last_ce_dat = '0;
   logic        last_ce_cw = 1'b0;
   logic [15:0] last_par_dat = '0;

   mil_rxd dut (
      .clk     (clk),
      .rst     (rst),
      .RXP     (RXP),
      .RXN     (RXN),
      .dat     (dat),
      .cw_dw   (cw_dw),
      .ce_wr   (ce_wr),
      .err_par (err_par),
      .err_man (err_man),
      .busy    (busy),
      .cb_bit  (cb_bit)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   // Free-running cycle count used for latency measurements.
   always @(posedge clk) cyc++;

   // Records every strobe and busy cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (ce_wr) begin
         ce_cnt++;
         prev_ce_cyc = last_ce_cyc;
         last_ce_cyc = cyc;
         last_ce_dat = dat;
         last_ce_cw  = cw_dw;
      end
      if (err_par) begin
         par_cnt++;
         last_par_dat = dat;
      end
      if (err_man) man_cnt++;
      if (busy) busy_cnt++;
   end

   // Hold a line level for n clocks: 1, 0, or -1 for idle.
   task automatic drive_line(input int lv, input int n);
      if (lv == 1) begin
         RXP = 1'b1; RXN = 1'b0;
      end else if (lv == 0) begin
         RXP = 1'b0; RXN = 1'b1;
      end else begin
         RXP = 1'b0; RXN = 1'b0;
      end
      repeat (n) @(negedge clk);
   endtask

   // Sync plus 17 Manchester cells; bad_bit >= 0 holds that cell constant.
   task automatic send_word(input logic cmd, input logic [15:0] data,
                            input logic flip_par, input int bad_bit,
                            input int bit_len);
      int h1, h2, sy1, sy2;
      logic [16:0] bits;
      h2   = bit_len / 2;
      h1   = bit_len - h2;
      sy2  = (3 * bit_len) / 2;
      sy1  = 3 * bit_len - sy2;
      bits = {data, (~^data) ^ flip_par};
      drive_line(cmd ? 1 : 0, sy1);
      drive_line(cmd ? 0 : 1, sy2);
      for (int i = 16; i >= 0; i--) begin
         if ((16 - i) == bad_bit) begin
            drive_line(int'(bits[i]), bit_len);
         end else begin
            drive_line(int'(bits[i]), h1);
            drive_line(int'(!bits[i]), h2);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive_line(-1, 4);
      checks++; if (dat !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dat: got %h expected 0000", dat); end
      checks++; if (cw_dw !== 1'b0) begin errors++; $display("[TB] FAIL reset_cw_dw: got %b expected 0", cw_dw); end
      checks++; if (ce_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce_wr: got %b expected 0", ce_wr); end
      checks++; if (err_par !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_par: got %b expected 0", err_par); end
      checks++; if (err_man !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_man: got %b expected 0", err_man); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (cb_bit !== 5'd0) begin errors++; $display("[TB] FAIL reset_cb_bit: got %0d expected 0", cb_bit); end
      rst = 1'b0;
      drive_line(-1, 20);
   endtask

   task automatic test_single_word;
      int c0, p0, m0, b0, t0;
      c0 = ce_cnt; p0 = par_cnt; m0 = man_cnt; b0 = busy_cnt; t0 = cyc;
      send_word(1'b1, 16'h1234, 1'b0, -1, 50);
      drive_line(-1, 40);
      checks++; if (ce_cnt - c0 !== 1) begin errors++; $display("[TB] FAIL single_ce_count: got %0d expected 1", ce_cnt - c0); end
      checks++; if (last_ce_dat !== 16'h1234) begin errors++; $display("[TB] FAIL single_dat: got %h expected 1234", last_ce_dat); end
      checks++; if (last_ce_cw !== 1'b1) begin errors++; $display("[TB] FAIL single_cw_dw: got %b expected 1", last_ce_cw); end
      checks++; if ((par_cnt - p0) + (man_cnt - m0) !== 0) begin errors++; $display("[TB] FAIL single_err_strobes: got %0d expected 0", (par_cnt - p0) + (man_cnt - m0)); end
      checks++; if ((last_ce_cyc - t0) < 989 || (last_ce_cyc - t0) > 993) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 989..993", last_ce_cyc - t0); end
      checks++; if ((busy_cnt - b0) < 910 || (busy_cnt - b0) > 918) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected 910..918", busy_cnt - b0); end
   endtask

   task automatic test_back_to_back;
      int c0;
      c0 = ce_cnt;
      send_word(1'b1, 16'h1234, 1'b0, -1, 50);
      send_word(1'b0, 16'h5678, 1'b0, -1, 50);
      drive_line(-1, 40);
      checks++; if (ce_cnt - c0 !== 2) begin errors++; $display("[TB] FAIL b2b_ce_count: got %0d expected 2", ce_cnt - c0); end
      checks++; if (last_ce_cyc - prev_ce_cyc !== 1000) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 1000", last_ce_cyc - prev_ce_cyc); end
      checks++; if (last_ce_dat !== 16'h5678) begin errors++; $display("[TB] FAIL b2b_dat: got %h expected 5678", last_ce_dat); end
      checks++; if (last_ce_cw !== 1'b0) begin errors++; $display("[TB] FAIL b2b_cw_dw: got %b expected 0", last_ce_cw); end
   endtask

   task automatic test_manchester_error;
      int c0, p0, m0;
      c0 = ce_cnt; p0 = par_cnt; m0 = man_cnt;
      send_word(1'b1, 16'h1234, 1'b0, 5, 50);
      drive_line(-1, 30);
      checks++; if (man_cnt - m0 !== 1) begin errors++; $display("[TB] FAIL man_err_count: got %0d expected 1", man_cnt - m0); end
      checks++; if ((ce_cnt - c0) + (par_cnt - p0) !== 0) begin errors++; $display("[TB] FAIL man_other_strobes: got %0d expected 0", (ce_cnt - c0) + (par_cnt - p0)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL man_busy: got %b expected 0", busy); end
      checks++; if (dat !== 16'h5678) begin errors++; $display("[TB] FAIL man_dat_hold: got %h expected 5678", dat); end
      c0 = ce_cnt;
      send_word(1'b1, 16'hA5A5, 1'b0, -1, 50);
      drive_line(-1, 40);
      checks++; if (ce_cnt - c0 !== 1) begin errors++; $display("[TB] FAIL man_next_ce: got %0d expected 1", ce_cnt - c0); end
      checks++; if (last_ce_dat !== 16'hA5A5) begin errors++; $display("[TB] FAIL man_next_dat: got %h expected a5a5", last_ce_dat); end
   endtask

   task automatic test_parity_error;
      int c0, p0, m0;
      c0 = ce_cnt; p0 = par_cnt; m0 = man_cnt;
      send_word(1'b0, 16'h5678, 1'b1, -1, 50);
      drive_line(-1, 40);
      checks++; if (par_cnt - p0 !== 1) begin errors++; $display("[TB] FAIL par_err_count: got %0d expected 1", par_cnt - p0); end
      checks++; if ((ce_cnt - c0) + (man_cnt - m0) !== 0) begin errors++; $display("[TB] FAIL par_other_strobes: got %0d expected 0", (ce_cnt - c0) + (man_cnt - m0)); end
      checks++; if (last_par_dat !== 16'h5678) begin errors++; $display("[TB] FAIL par_dat: got %h expected 5678", last_par_dat); end
   endtask

   task automatic test_short_sync;
      int c0, p0, m0, b0;
      c0 = ce_cnt; p0 = par_cnt; m0 = man_cnt; b0 = busy_cnt;
      drive_line(1, 40);
      drive_line(0, 40);
      drive_line(-1, 100);
      checks++; if ((ce_cnt - c0) + (par_cnt - p0) + (man_cnt - m0) !== 0) begin errors++; $display("[TB] FAIL short_strobes: got %0d expected 0", (ce_cnt - c0) + (par_cnt - p0) + (man_cnt - m0)); end
      checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("[TB] FAIL short_busy: got %0d expected 0", busy_cnt - b0); end
   endtask

   task automatic test_stretched;
      int c0, m0;
      c0 = ce_cnt; m0 = man_cnt;
      send_word(1'b1, 16'hFFFF, 1'b0, -1, 53);
      drive_line(-1, 40);
      checks++; if (ce_cnt - c0 !== 1) begin errors++; $display("[TB] FAIL stretch_ce_count: got %0d expected 1", ce_cnt - c0); end
      checks++; if (last_ce_dat !== 16'hFFFF) begin errors++; $display("[TB] FAIL stretch_dat: got %h expected ffff", last_ce_dat); end
      checks++; if (man_cnt - m0 !== 0) begin errors++; $display("[TB] FAIL stretch_man: got %0d expected 0", man_cnt - m0); end
   endtask

   task automatic test_reset_mid_word;
      int c0, p0, m0;
      c0 = ce_cnt; p0 = par_cnt; m0 = man_cnt;
      fork
         send_word(1'b1, 16'h1234, 1'b0, -1, 50);
         begin
            repeat (570) @(negedge clk);
            checks++; if (cb_bit !== 5'd8) begin errors++; $display("[TB] FAIL midrst_cb_bit: got %0d expected 8", cb_bit); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
            rst = 1'b1;
            @(negedge clk);
            checks++; if (dat !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_dat: got %h expected 0000", dat); end
            checks++; if (cw_dw !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cw_dw: got %b expected 0", cw_dw); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
            checks++; if (cb_bit !== 5'd0) begin errors++; $display("[TB] FAIL midrst_cb_bit_clr: got %0d expected 0", cb_bit); end
            rst = 1'b0;
         end
      join
      drive_line(-1, 40);
      checks++; if ((ce_cnt - c0) + (par_cnt - p0) + (man_cnt - m0) !== 0) begin errors++; $display("[TB] FAIL midrst_strobes: got %0d expected 0", (ce_cnt - c0) + (par_cnt - p0) + (man_cnt - m0)); end
      c0 = ce_cnt;
      send_word(1'b1, 16'h1234, 1'b0, -1, 50);
      drive_line(-1, 40);
      checks++; if (ce_cnt - c0 !== 1) begin errors++; $display("[TB] FAIL midrst_next_ce: got %0d expected 1", ce_cnt - c0); end
      checks++; if (last_ce_dat !== 16'h1234) begin errors++; $display("[TB] FAIL midrst_next_dat: got %h expected 1234", last_ce_dat); end
   endtask

   // Scenario sequence.
   initial begin
      @(negedge clk);
      $display("[TB] starting mil_rxd directed tests");
      test_reset();
      test_single_word();
      test_back_to_back();
      test_manchester_error();
      test_parity_error();
      test_short_sync();
      test_stretched();
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
